// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus memory slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_mem_pkg;

  // Slave control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRESP = 2'd2,
    RRESP = 2'd3
  } state_t;

  localparam logic BUS_MODE_WRITE = 1'b1;
  localparam logic BUS_MODE_READ  = 1'b0;

  // Data returned for a read of an illegal address (error build only).
  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous word RAM with one write port and a registered read.
// Latency: write lands at the enabling edge; read data is valid after the enabling edge.
// Backpressure: none; the caller owns the enables.
// Ports: clk, rst_n (clears only the read register), i_addr word index,
//        i_we/i_wdata write, i_re read enable, o_rdata registered read data.
module bus_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic                     i_we,
  input  logic [31:0]              i_wdata,
  input  logic                     i_re,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage is deliberately left out of reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // The read register is reset so the bus sees zero read data during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_slave.sv
// CPU-bus memory slave: one request at a time, fixed wait latency, then a write pulse or a held read.
// Latency: response visible in the cycle after edge E+LATENCY (E = acceptance edge).
// Backpressure: read data held until BUS_rready; BUS_valid ignored while a request is in flight.
// Ports: clk, rst_n (async, active-low); BUS_addr/BUS_wdata/BUS_mode/BUS_valid request;
//        BUS_wready write-complete pulse; BUS_rdata/BUS_rvalid/BUS_rready read response.
// Optional BUS_MEM_ERR_EN: adds BUS_err, flags misaligned/out-of-range addresses,
// suppresses such writes and returns 32'hDEADBEEF for such reads.
// Assumes DEPTH <= 2**29 so the index never reaches address bit 31.
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  output logic        BUS_wready,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rvalid,
  input  logic        BUS_rready
`ifdef BUS_MEM_ERR_EN
  ,
  output logic        BUS_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_mode;
  logic [31:0]   r_wdata;
  logic          r_err;      // latched request had an illegal address
  logic          r_err_rsp;  // error flag shown alongside the response
  logic          r_rd_err;   // last read response used the error pattern
  logic          r_wready;
  logic          r_rvalid;

  logic [AW-1:0] w_idx;
  logic          w_addr_bad;
  logic          w_resp_edge;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [31:0]   w_ram_rdata;

  assign w_idx = BUS_addr[AW+1:2];

`ifdef BUS_MEM_ERR_EN
  assign w_addr_bad = (BUS_addr[1:0] != 2'b00) || ((BUS_addr >> (AW + 2)) != 32'd0);
  assign BUS_err    = r_err_rsp;
`else
  // Byte-offset and upper address bits are don't-care: addresses wrap.
  logic w_unused;
  assign w_addr_bad = 1'b0;
  assign w_unused   = ^{BUS_addr[31:AW+2], BUS_addr[1:0], r_err_rsp};
`endif

  // The edge that leaves WAIT is the edge that enters the response state,
  // so the RAM write or read is issued on exactly that edge.
  assign w_resp_edge = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_ram_we    = w_resp_edge && (r_mode == BUS_MODE_WRITE) && !r_err;
  assign w_ram_re    = w_resp_edge && (r_mode == BUS_MODE_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_mode    <= BUS_MODE_READ;
      r_wdata   <= 32'h0;
      r_err     <= 1'b0;
      r_err_rsp <= 1'b0;
      r_rd_err  <= 1'b0;
      r_wready  <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (BUS_valid) begin
            r_idx   <= w_idx;
            r_mode  <= BUS_mode;
            r_wdata <= BUS_wdata;
            r_err   <= w_addr_bad;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_err_rsp <= r_err;
            if (r_mode == BUS_MODE_WRITE) begin
              r_wready <= 1'b1;
              r_state  <= WRESP;
            end else begin
              r_rvalid <= 1'b1;
              r_rd_err <= r_err;
              r_state  <= RRESP;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRESP: begin
          r_wready  <= 1'b0;
          r_err_rsp <= 1'b0;
          r_state   <= IDLE;
        end
        RRESP: begin
          if (BUS_rready) begin
            r_rvalid  <= 1'b0;
            r_err_rsp <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bus_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_addr  (r_idx),
    .i_we    (w_ram_we),
    .i_wdata (r_wdata),
    .i_re    (w_ram_re),
    .o_rdata (w_ram_rdata)
  );

  // The select only changes on read-response entry, so BUS_rdata stays put otherwise.
  assign BUS_rdata  = r_rd_err ? BUS_ERR_RDATA : w_ram_rdata;
  assign BUS_wready = r_wready;
  assign BUS_rvalid = r_rvalid;

endmodule
